// File: rtl/conv2d_out_packer.sv
// Packs a serial element stream into PE-wide words, tags frame ends and buffers words in a small FIFO.
// Optional status outputs (overflow, drop_count) are built only with CONV2D_OUT_PACKER_STATUS_EN defined.
module conv2d_out_packer #(
    parameter int PE         = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PIXELS     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       valid_in,
    output logic [PE*DATA_WIDTH-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
`ifdef CONV2D_OUT_PACKER_STATUS_EN
    ,
    output logic                       overflow,
    output logic [15:0]                drop_count
`endif
);

    localparam int WORD_W = PE * DATA_WIDTH;
    localparam int LANE_W = (PE > 1) ? $clog2(PE) : 1;
    localparam int WIDX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [WORD_W-1:0] partial_q, partial_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [WORD_W-1:0] mem_data_q [FIFO_DEPTH];
    logic              mem_last_q [FIFO_DEPTH];

    logic [WORD_W-1:0] assembled;
    logic              word_done;
    logic              word_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              drop;

    // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_data/out_last hold the FIFO head until then. The input side has no backpressure.
    always_comb begin
        assembled = partial_q;
        for (int k = 0; k < PE; k++) begin
            if (lane_q == LANE_W'(k)) begin
                assembled[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
        end
        word_done  = valid_in && (lane_q == LANE_W'(PE - 1));
        word_last  = (word_idx_q == WIDX_W'(PIXELS - 1));
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && out_ready;
        // A full FIFO still takes the word when the head leaves on the same edge.
        push       = word_done && (!fifo_full || pop);
        drop       = word_done && fifo_full && !pop;
    end

    always_comb begin
        lane_d     = lane_q;
        word_idx_d = word_idx_q;
        partial_d  = partial_q;
        if (valid_in) begin
            partial_d = assembled;
            if (word_done) begin
                lane_d     = '0;
                word_idx_d = word_last ? '0 : word_idx_q + WIDX_W'(1);
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q     <= '0;
            word_idx_q <= '0;
            partial_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            lane_q     <= lane_d;
            word_idx_q <= word_idx_d;
            partial_q  <= partial_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: its contents are only visible while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= assembled;
            mem_last_q[wr_ptr_q] <= word_last;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
    assign out_last  = !fifo_empty && mem_last_q[rd_ptr_q];

`ifdef CONV2D_OUT_PACKER_STATUS_EN
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_conv2d_out_packer.sv
// Bench for conv2d_out_packer (PE=4, DATA_WIDTH=8, PIXELS=2, FIFO_DEPTH=4): vector table plus scoreboard.
// Status outputs are checked only when CONV2D_OUT_PACKER_STATUS_EN is defined.
module tb_conv2d_out_packer;

    localparam int PE     = 4;
    localparam int DW     = 8;
    localparam int PIXELS = 2;
    localparam int DEPTH  = 4;
    localparam int W      = PE * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
`ifdef CONV2D_OUT_PACKER_STATUS_EN
    logic          overflow;
    logic [15:0]   drop_count;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard: {last, data} of every word the DUT should still hold, oldest first.
    logic [W:0] exp_q[$];
    int         m_lane = 0;
    int         m_word = 0;
    logic [W-1:0] m_part = '0;
    int         m_drops = 0;

    conv2d_out_packer #(
        .PE(PE), .DATA_WIDTH(DW), .PIXELS(PIXELS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .valid_in(valid_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
`ifdef CONV2D_OUT_PACKER_STATUS_EN
        ,
        .overflow(overflow),
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after a rising edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        valid_in  = v;
        data_in   = d;
        out_ready = r;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cyc(1'b0, DW'($urandom_range(0, 255)), 1'b1);
        cyc(1'b0, DW'($urandom_range(0, 255)), 1'b0);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model evaluated mid-cycle with the inputs the next edge will sample.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_lane  = 0;
            m_word  = 0;
            m_part  = '0;
            m_drops = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
        end else begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(exp_q[0][W-1:0]));
                chk("out_last", 64'(out_last), 64'(exp_q[0][W]));
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("idle_out_last", 64'(out_last), 64'd0);
            end
            if (valid_in) begin
                m_part[m_lane*DW +: DW] = data_in;
                if (m_lane == PE - 1) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({(m_word == PIXELS - 1), m_part});
                    else if (m_drops < 65535) m_drops++;
                    m_word = (m_word == PIXELS - 1) ? 0 : m_word + 1;
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
        end
`ifdef CONV2D_OUT_PACKER_STATUS_EN
        if (rst) begin
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("overflow", 64'(overflow), 64'(m_drops != 0));
        end
`endif
    end

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          ev;
        logic [W-1:0]  ed;
        logic          el;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    task automatic setv(input int i, input logic v, input logic [DW-1:0] d,
                        input logic ev, input logic [W-1:0] ed, input logic el);
        tbl[i].v  = v;
        tbl[i].d  = v ? d : DW'($urandom_range(0, 255));
        tbl[i].r  = 1'b1;
        tbl[i].ev = ev;
        tbl[i].ed = ed;
        tbl[i].el = el;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two words with gaps (frame of two), then one four-element burst starting a new frame.
        setv(0,  1, 8'h01, 0, '0, 0);
        setv(1,  0, 8'h00, 0, '0, 0);
        setv(2,  1, 8'h02, 0, '0, 0);
        setv(3,  1, 8'h03, 0, '0, 0);
        setv(4,  0, 8'h00, 0, '0, 0);
        setv(5,  1, 8'h04, 1, 32'h04030201, 0);
        setv(6,  1, 8'h05, 0, '0, 0);
        setv(7,  0, 8'h00, 0, '0, 0);
        setv(8,  1, 8'h06, 0, '0, 0);
        setv(9,  1, 8'h07, 0, '0, 0);
        setv(10, 0, 8'h00, 0, '0, 0);
        setv(11, 1, 8'h08, 1, 32'h08070605, 1);
        setv(12, 0, 8'h00, 0, '0, 0);
        setv(13, 1, 8'h11, 0, '0, 0);
        setv(14, 1, 8'h22, 0, '0, 0);
        setv(15, 1, 8'h33, 0, '0, 0);
        setv(16, 1, 8'h44, 1, 32'h44332211, 0);
        setv(17, 0, 8'h00, 0, '0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i <= NV; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                chk("tbl_valid", 64'(out_valid), 64'(tbl[i-1].ev));
                chk("tbl_last", 64'(out_last), 64'(tbl[i-1].el));
                if (tbl[i-1].ev) chk("tbl_data", 64'(out_data), 64'(tbl[i-1].ed));
            end
            if (i < NV) begin
                valid_in = tbl[i].v; data_in = tbl[i].d; out_ready = tbl[i].r;
            end else begin
                valid_in = 1'b0; out_ready = 1'b0;
            end
        end

        // Five words with no drain: four buffered, the fifth dropped.
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(i + 1), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_head_valid", 64'(out_valid), 64'd1);
        chk("ovf_head_data", 64'(out_data), 64'h04030201);
`ifdef CONV2D_OUT_PACKER_STATUS_EN
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop_count", 64'(drop_count), 64'd1);
`endif
        drain("ovf_drain");
        chk("ovf_empty", 64'(out_valid), 64'd0);

        // Full FIFO while a word completes in the same cycle as a pop: nothing dropped.
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        cyc(1'b1, DW'($urandom_range(0, 255)), 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("full_pop_occupancy", 64'(exp_q.size()), 64'd4);
`ifdef CONV2D_OUT_PACKER_STATUS_EN
        chk("full_pop_drop_count", 64'(drop_count), 64'd1);
`endif
        drain("full_pop_drain");

        // Reset mid-word with a buffered word, then a fresh word.
        for (int i = 0; i < 6; i++) cyc(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        #2;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 8'hA1, 1'b1);
        cyc(1'b1, 8'hA2, 1'b1);
        cyc(1'b1, 8'hA3, 1'b1);
        cyc(1'b1, 8'hA4, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'hA4A3A2A1);
        chk("post_rst_last", 64'(out_last), 64'd0);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_out_packer.md
CONV2D_OUT_PACKER -- requirements
Module: conv2d_out_packer

Interface
REQ-001 SHALL have parameter PE, default 16: elements packed per output word.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per element.
REQ-003 SHALL have parameter PIXELS, default 64: output words per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): output word buffer depth.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, DATA_WIDTH: element from the conv2d_hls output stream.
REQ-008 SHALL have port valid_in, input, 1: data_in valid; no backpressure toward the source.
REQ-009 SHALL have port out_data, output, PE*DATA_WIDTH: packed word.
REQ-010 SHALL have port out_valid, output, 1: out_data valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port out_last, output, 1: word is the final word (word PIXELS-1) of a frame.

Function
REQ-013 SHALL accept one element every cycle valid_in=1, placing element k (0-based in the current word) at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-014 SHALL count lanes 0..PE-1 and wrap to 0 on the PE-th accepted element; that element completes the word.
REQ-015 SHALL count words 0..PIXELS-1, increment on each completed word (pushed or dropped), and wrap to 0 after PIXELS-1; word index PIXELS-1 is tagged last.
REQ-016 SHALL push the completed word, with its last tag, into the FIFO on the completing cycle; if FIFO empty, out_valid=1 on the next cycle (latency 1 from the completing element).
REQ-017 SHALL present FIFO head on out_data/out_last while out_valid=1, hold them stable until the handshake, and pop on out_valid && out_ready.
REQ-018 SHALL allow push when the FIFO is full if a pop occurs in the same cycle; occupancy is then unchanged.
REQ-019 SHALL drop a completed word when the FIFO is full and no pop occurs that cycle; lane and word counters still advance, so frame alignment is kept.
REQ-020 SHALL deassert out_valid when the FIFO is empty; out_data is don't-care then and out_last=0.
REQ-021 SHALL leave counters and the partial word unchanged on cycles with valid_in=0.
REQ-022 SHALL store occupancy in a counter of width clog2(FIFO_DEPTH)+1, with read/write pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-023 SHALL, while rst=0, asynchronously clear lane counter, word counter, partial word, FIFO pointers and occupancy; out_valid=0, out_last=0, out_data=0.
REQ-024 SHALL discard any partial word and buffered words on reset mid-frame; the first element after release is lane 0 of word 0.
REQ-025 SHALL accept no element on the clock edge where rst deasserts unless valid_in=1 at that edge, which is then lane 0.

Configuration
REQ-026 SHALL, when CONV2D_OUT_PACKER_STATUS_EN is defined, add output overflow (1 bit, sticky, set in the cycle after the first dropped word, cleared only by reset) and output drop_count (16 bits, increments per dropped word, saturates at 0xFFFF).
REQ-027 SHALL, when CONV2D_OUT_PACKER_STATUS_EN is undefined, omit both ports and their logic; drop behaviour per REQ-019 is unchanged.

Verification (PE=4, DATA_WIDTH=8, PIXELS=2, FIFO_DEPTH=4)
REQ-028 SHALL cover: elements 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> out_data=0x44332211, out_valid for one cycle, one cycle after 0x44; out_last=0.
REQ-029 SHALL cover: 8 elements 0x01..0x08 with valid gaps -> words 0x04030201 (last=0) then 0x08070605 (last=1); the next word has last=0.
REQ-030 SHALL cover: out_ready=0, 20 elements (5 words) -> 4 words buffered, 5th dropped, overflow=1, drop_count=1; releasing out_ready drains words 1-4 in order.
REQ-031 SHALL cover: FIFO full, word completes in the same cycle as a pop -> no drop, occupancy stays 4, drop_count unchanged.
REQ-032 SHALL cover: rst low for one cycle after 2 elements of a word, then 4 new elements 0xA1..0xA4 -> out_data=0xA4A3A2A1, out_last=0; all outputs 0 during reset.
